// File: rtl/jtcps1_arb_pkg.sv
// Shared types and sizing helpers for the CPS1/CPS2 SDRAM bank arbiter.
package jtcps1_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      RFSH  = 2'd3
   } arb_state_t;

   localparam int NBANKS = 4;

   // Fixed-priority search order, slot k in bits [2k+1:2k]: 0, 1, 3, 2
   localparam logic [7:0] FIXED_PRIO = {2'd2, 2'd3, 2'd1, 2'd0};

   function automatic int tmr_width(input int period);
      return (period > 2) ? $clog2(period) : 1;
   endfunction

   function automatic int pend_width(input int maxpend);
      return (maxpend > 1) ? $clog2(maxpend + 1) : 1;
   endfunction

endpackage

// File: rtl/jtcps1_arb_sel.sv
// Combinational winner select for the bank arbiter.
// JTCPS1_BANK_RR_EN selects round-robin from ptr; otherwise fixed order 0,1,3,2.
import jtcps1_arb_pkg::*;

module jtcps1_arb_sel (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] gnt,
   output logic [1:0] bank
);

   logic       found;
   logic [1:0] idx;

`ifndef JTCPS1_BANK_RR_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;
`endif

   always_comb begin
      gnt   = '0;
      bank  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NBANKS; k++) begin
`ifdef JTCPS1_BANK_RR_EN
         idx = ptr + 2'(k);
`else
         idx = FIXED_PRIO[2*k +: 2];
`endif
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            bank     = idx;
         end
      end
   end

endmodule

// File: rtl/jtcps1_bank_arb.sv
// SDRAM access scheduler: grants one bank at a time and schedules auto-refresh.
// Optional macro JTCPS1_BANK_RR_EN enables round-robin arbitration.
import jtcps1_arb_pkg::*;

module jtcps1_bank_arb #(
   parameter int SDRAMW       = 23,
   parameter int RFSH_PERIOD  = 750,
   parameter int RFSH_MAXPEND = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        ba_rd,
   input  logic              ba_wr,
   input  logic [SDRAMW-1:0] ba0_addr,
   input  logic [SDRAMW-1:0] ba1_addr,
   input  logic [SDRAMW-1:0] ba2_addr,
   input  logic [SDRAMW-1:0] ba3_addr,
   input  logic [15:0]       ba0_din,
   input  logic [1:0]        ba0_din_m,
   output logic [3:0]        ba_ack,
   output logic [3:0]        ba_dst,
   output logic [3:0]        ba_rdy,
   input  logic              rfsh_en,
   output logic              sdram_req,
   output logic              sdram_we,
   output logic [1:0]        sdram_ba,
   output logic [SDRAMW-1:0] sdram_addr,
   output logic [15:0]       sdram_din,
   output logic [1:0]        sdram_mask,
   output logic              sdram_rfsh,
   input  logic              sdram_gnt,
   input  logic              sdram_dst,
   input  logic              sdram_rdy
);

   localparam int TW = tmr_width(RFSH_PERIOD);
   localparam int PW = pend_width(RFSH_MAXPEND);
   localparam logic [TW-1:0] TMR_LAST = TW'(RFSH_PERIOD - 1);
   localparam logic [PW-1:0] PEND_MAX = PW'(RFSH_MAXPEND);

   arb_state_t        state_reg, state_next;
   logic [1:0]        owner_reg;
   logic [SDRAMW-1:0] addr_reg;
   logic              we_reg;
   logic [15:0]       din_reg;
   logic [1:0]        mask_reg;
   logic              rfsh_gnt_reg, rfsh_gnt_next;
   logic [TW-1:0]     tmr_reg;
   logic [PW-1:0]     pend_reg, pend_next;

   logic              load, rfsh_take, tmr_wrap, rfsh_due;
   logic [3:0]        owner_oh, win_gnt;
   logic [1:0]        win_bank, ptr;
   logic [SDRAMW-1:0] win_addr;
   logic [SDRAMW-1:0] addr_arr [NBANKS];

   assign addr_arr[0] = ba0_addr;
   assign addr_arr[1] = ba1_addr;
   assign addr_arr[2] = ba2_addr;
   assign addr_arr[3] = ba3_addr;

`ifdef JTCPS1_BANK_RR_EN
   logic [1:0] ptr_reg;
   assign ptr = ptr_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr_reg <= 2'd0;
      else if (load)
         ptr_reg <= win_bank + 2'd1;
   end
`else
   assign ptr = 2'd0;
`endif

   jtcps1_arb_sel u_sel (
      .req  (ba_rd),
      .ptr  (ptr),
      .gnt  (win_gnt),
      .bank (win_bank)
   );

   always_comb begin
      win_addr = '0;
      for (int i = 0; i < NBANKS; i++)
         if (win_gnt[i]) win_addr = win_addr | addr_arr[i];
   end

   assign owner_oh   = 4'b0001 << owner_reg;
   assign tmr_wrap   = (tmr_reg == TMR_LAST);
   assign rfsh_due   = ((pend_reg != '0) && rfsh_en) || (pend_reg == PEND_MAX);

   assign sdram_ba   = owner_reg;
   assign sdram_addr = addr_reg;
   assign sdram_we   = we_reg;
   assign sdram_din  = din_reg;
   assign sdram_mask = mask_reg;

   always_comb begin
      state_next    = state_reg;
      rfsh_gnt_next = rfsh_gnt_reg;
      load          = 1'b0;
      rfsh_take     = 1'b0;
      sdram_req     = 1'b0;
      sdram_rfsh    = 1'b0;
      ba_ack        = '0;
      ba_dst        = '0;
      ba_rdy        = '0;
      case (state_reg)
         IDLE: begin
            if (rfsh_due) begin
               state_next = RFSH;
            end else if (ba_rd != '0) begin
               load       = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            sdram_req = 1'b1;
            if (sdram_gnt) begin
               ba_ack     = owner_oh;
               state_next = BUSY;
            end
         end
         BUSY: begin
            ba_dst = sdram_dst ? owner_oh : 4'd0;
            ba_rdy = sdram_rdy ? owner_oh : 4'd0;
            if (sdram_rdy) state_next = IDLE;
         end
         RFSH: begin
            if (!rfsh_gnt_reg) begin
               sdram_rfsh = 1'b1;
               if (sdram_gnt) begin
                  rfsh_take     = 1'b1;
                  rfsh_gnt_next = 1'b1;
               end
            end else if (sdram_rdy) begin
               rfsh_gnt_next = 1'b0;
               state_next    = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A wrap and a refresh grant in the same cycle cancel out
   always_comb begin
      pend_next = pend_reg;
      if (tmr_wrap && !rfsh_take) begin
         if (pend_reg != PEND_MAX) pend_next = pend_reg + PW'(1);
      end else if (!tmr_wrap && rfsh_take) begin
         pend_next = pend_reg - PW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         rfsh_gnt_reg <= 1'b0;
         tmr_reg      <= '0;
         pend_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         rfsh_gnt_reg <= rfsh_gnt_next;
         tmr_reg      <= tmr_wrap ? '0 : tmr_reg + TW'(1);
         pend_reg     <= pend_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_reg <= 2'd0;
         addr_reg  <= '0;
         we_reg    <= 1'b0;
         din_reg   <= '0;
         mask_reg  <= '0;
      end else if (load) begin
         owner_reg <= win_bank;
         addr_reg  <= win_addr;
         we_reg    <= win_gnt[0] & ba_wr;
         din_reg   <= (win_gnt[0] & ba_wr) ? ba0_din   : 16'd0;
         mask_reg  <= (win_gnt[0] & ba_wr) ? ba0_din_m : 2'd0;
      end
   end

endmodule

// File: tb/tb_jtcps1_bank_arb.sv
// Scoreboard bench for jtcps1_bank_arb with a randomized engine model.
module tb_jtcps1_bank_arb;

   localparam int AW  = 23;
   localparam int PER = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    ba_rd = 4'd0;
   logic          ba_wr = 1'b0;
   logic [AW-1:0] a [4];
   logic [15:0]   ba0_din = 16'd0;
   logic [1:0]    ba0_din_m = 2'd0;
   logic [3:0]    ba_ack, ba_dst, ba_rdy;
   logic          rfsh_en = 1'b0;
   logic          sdram_req, sdram_we, sdram_rfsh;
   logic [1:0]    sdram_ba, sdram_mask;
   logic [AW-1:0] sdram_addr;
   logic [15:0]   sdram_din;
   logic          sdram_gnt = 1'b0, sdram_dst = 1'b0, sdram_rdy = 1'b0;

   always #5 clk = ~clk;

   jtcps1_bank_arb #(.SDRAMW(AW), .RFSH_PERIOD(PER), .RFSH_MAXPEND(3)) dut (
      .clk(clk), .rst(rst), .ba_rd(ba_rd), .ba_wr(ba_wr),
      .ba0_addr(a[0]), .ba1_addr(a[1]), .ba2_addr(a[2]), .ba3_addr(a[3]),
      .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
      .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_rdy(ba_rdy), .rfsh_en(rfsh_en),
      .sdram_req(sdram_req), .sdram_we(sdram_we), .sdram_ba(sdram_ba),
      .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_mask(sdram_mask),
      .sdram_rfsh(sdram_rfsh), .sdram_gnt(sdram_gnt), .sdram_dst(sdram_dst),
      .sdram_rdy(sdram_rdy)
   );

   typedef struct {
      int            bank;
      logic [AW-1:0] addr;
      logic          we;
      logic [15:0]   din;
      logic [1:0]    mask;
   } exp_t;

   exp_t       exp_q[$];
   int         n_cmp = 0, n_err = 0;
   int         m_last = 3;
   int         cur_owner = 0, rf_grants = 0, n_ack = 0;
   int         e_st = 0, e_cnt = 0;
   logic       e_rf = 1'b0;
   int         req_seq = 0, seen_seq = 0;
   logic [3:0] nxt_req = 4'd0, nxt_drop = 4'd0, drop_mask = 4'd0;
   int         nxt_hold = 0, hold_left = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
      n_cmp++;
      if (act !== req_v) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req_v, $time);
      end
   endtask

   function automatic logic [63:0] outs_vec();
      return {6'd0, ba_ack, ba_dst, ba_rdy, sdram_req, sdram_we, sdram_ba,
              sdram_rfsh, sdram_mask, sdram_addr, sdram_din};
   endfunction

   // Reference arbitration rule: next bank that the spec's search order reaches
   function automatic int pick(input logic [3:0] r, input int last);
      int order [4];
      order = '{0, 1, 3, 2};
`ifdef JTCPS1_BANK_RR_EN
      for (int k = 1; k <= 4; k++)
         if (r[(last + k) % 4]) return (last + k) % 4;
`else
      for (int k = 0; k < 4; k++)
         if (r[order[k]]) return order[k];
`endif
      return -1;
   endfunction

   // Engine model: randomized grant, data-start and ready latencies
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            e_st = 0; sdram_gnt = 0; sdram_dst = 0; sdram_rdy = 0;
         end else begin
            case (e_st)
               0: if (sdram_rfsh || sdram_req) begin
                     e_rf = sdram_rfsh; e_cnt = $urandom_range(0, 2); e_st = 1;
                     if (e_cnt == 0) begin sdram_gnt = 1; e_st = 2; end
                  end
               1: if (e_cnt <= 1) begin sdram_gnt = 1; e_st = 2; end else e_cnt--;
               2: begin sdram_gnt = 0; e_cnt = $urandom_range(1, 3); e_st = 3; end
               3: if (e_cnt <= 1) begin sdram_dst = 1; e_st = 4; end else e_cnt--;
               4: begin sdram_dst = 0; e_cnt = $urandom_range(1, 3); e_st = 5; end
               5: if (e_cnt <= 1) begin sdram_rdy = 1; e_st = 6; end else e_cnt--;
               default: begin sdram_rdy = 0; e_st = 0; end
            endcase
         end
      end
   end

   // Monitor: owns ba_rd, pops the scoreboard on every client grant
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            ba_rd = 4'd0; hold_left = 0; drop_mask = 4'd0; seen_seq = req_seq;
            chk("reset_outputs", outs_vec(), 64'd0);
         end else begin
            if (sdram_gnt && !e_rf) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_grant", {60'd0, ba_ack}, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  n_ack++;
                  chk("ack_bank", {60'd0, ba_ack}, 64'(4'b0001 << e.bank));
                  chk("sdram_ba", {62'd0, sdram_ba}, 64'(e.bank));
                  chk("sdram_addr", 64'(sdram_addr), 64'(e.addr));
                  chk("sdram_we", {63'd0, sdram_we}, {63'd0, e.we});
                  if (e.we) begin
                     chk("sdram_din", 64'(sdram_din), 64'(e.din));
                     chk("sdram_mask", 64'(sdram_mask), 64'(e.mask));
                  end
                  cur_owner = e.bank;
                  if (hold_left > 0) begin
                     hold_left--;
                     if (hold_left == 0) ba_rd = 4'd0;
                  end else begin
                     ba_rd[e.bank] = 1'b0;
                  end
               end
            end else if (ba_ack != 4'd0) begin
               chk("ack_outside_grant", {60'd0, ba_ack}, 64'd0);
            end
            if (sdram_gnt && e_rf) rf_grants++;
            chk("ba_dst", {60'd0, ba_dst},
                (sdram_dst && !e_rf && e_st == 4) ? 64'(4'b0001 << cur_owner) : 64'd0);
            chk("ba_rdy", {60'd0, ba_rdy},
                (sdram_rdy && !e_rf && e_st == 6) ? 64'(4'b0001 << cur_owner) : 64'd0);
            if (sdram_req && hold_left == 0 && drop_mask[sdram_ba])
               ba_rd[sdram_ba] = 1'b0;
            if (seen_seq != req_seq) begin
               ba_rd = nxt_req; hold_left = nxt_hold; drop_mask = nxt_drop;
               seen_seq = req_seq;
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      m_last = 3;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic run_round(input logic [3:0] req, input logic [3:0] drop,
                            input int hold, input bit rnd);
      logic [3:0] pend;
      int         w, acks0;
      bit         done;
      exp_t       e;
      if (rnd) begin
         for (int b = 0; b < 4; b++) a[b] = AW'($urandom);
         ba_wr     = 1'($urandom);
         ba0_din   = 16'($urandom);
         ba0_din_m = 2'($urandom);
      end
      pend = req;
      for (int i = 0; i < ((hold > 0) ? hold : 4); i++) begin
         if (pend != 4'd0) begin
            w = pick(pend, m_last);
            e.bank = w; e.addr = a[w]; e.we = (w == 0) && ba_wr;
            e.din = ba0_din; e.mask = ba0_din_m;
            exp_q.push_back(e);
            if (hold == 0) pend[w] = 1'b0;
            m_last = w;
         end
      end
      acks0 = n_ack;
      nxt_req = req; nxt_hold = hold; nxt_drop = drop;
      req_seq++;
      done = 0;
      for (int c = 0; c < 3000 && !done; c++) begin
         @(posedge clk); #2;
         if (seen_seq == req_seq && exp_q.size() == 0 && ba_rd == 4'd0 && e_st == 0)
            done = 1;
      end
      chk("round_complete", {63'd0, done}, 64'd1);
      $display("round req=%b drop=%b hold=%0d acks=%0d rfsh=%0d", req, drop, hold,
               n_ack - acks0, rf_grants);
      if (!done) exp_q.delete();
   endtask

   initial begin
      int   base;
      bit   ok;
      exp_t e;
      for (int b = 0; b < 4; b++) a[b] = '0;

      // Refresh with clients idle and window open: one per period
      do_reset();
      rfsh_en = 1'b1;
      base = rf_grants;
      repeat (10 * PER + 10) @(posedge clk);
      chk("rfsh_open_count", 64'(rf_grants - base), 64'd10);

      // Window closed: nothing until three are pending, then forced
      do_reset();
      rfsh_en = 1'b0;
      base = rf_grants;
      repeat (50) @(posedge clk);
      chk("rfsh_closed_none", 64'(rf_grants - base), 64'd0);
      repeat (25) @(posedge clk);
      chk("rfsh_forced_one", 64'(rf_grants - base), 64'd1);
      base = rf_grants;
      run_round(4'hF, 4'd0, 16, 1);
      chk("rfsh_forced_vs_clients", {63'd0, (rf_grants - base) >= 1}, 64'd1);

      // Single bank 2 read and bank 0 write
      do_reset();
      rfsh_en = 1'b1;
      a[2] = 23'h12345;
      run_round(4'b0100, 4'd0, 0, 0);
      a[0] = AW'($urandom); ba_wr = 1'b1; ba0_din = 16'hBEEF; ba0_din_m = 2'b01;
      run_round(4'b0001, 4'd0, 0, 0);

      // Contention and dropped request
      do_reset();
      run_round(4'hF, 4'd0, 8, 1);
      run_round(4'b0010, 4'b0010, 0, 1);

      // Reset while bank 3 is in its data phase
      a[3] = AW'($urandom);
      e.bank = 3; e.addr = a[3]; e.we = 1'b0; e.din = '0; e.mask = '0;
      exp_q.push_back(e);
      m_last = 3;
      nxt_req = 4'b1000; nxt_hold = 0; nxt_drop = 4'd0;
      req_seq++;
      ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(posedge clk); #2;
         if (e_st >= 3 && exp_q.size() == 0 && cur_owner == 3) ok = 1;
      end
      chk("bank3_busy_reached", {63'd0, ok}, 64'd1);
      rst = 1'b1;
      #1 chk("reset_mid_busy", outs_vec(), 64'd0);
      exp_q.delete();
      m_last = 3;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      run_round(4'hF, 4'd0, 0, 1);

      // Randomized rounds
      for (int r = 0; r < 40; r++) begin
         rfsh_en = 1'($urandom);
         run_round(4'($urandom_range(1, 15)), 4'($urandom),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(2, 6) : 0, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/jtcps1_bank_arb.md
# jtcps1_bank_arb

Single-port SDRAM access scheduler for the CPS1/CPS2 memory map. It sits between the four bank clients (bank 0 CPU RAM/VRAM/ROM/sound with writes, bank 1 PCM, bank 2 CPS2 object ROM, bank 3 object/scroll/star ROM) and the SDRAM command engine. It grants one transaction at a time and steers the engine's data strobes back to the owning bank. It also schedules auto-refresh, preferring blanking time and forcing refresh when too many periods are missed.

## Interface
Parameters:
- SDRAMW, 23, SDRAM word-address width
- RFSH_PERIOD, 750, clk cycles between refresh requests (≈7.8 µs at 96 MHz)
- RFSH_MAXPEND, 3, pending-refresh count that forces a refresh regardless of rfsh_en

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  SDRAM clock
- rst  in  1  asynchronous, active-high reset
- ba_rd  in  4  per-bank read request, held until matching ba_ack
- ba_wr  in  1  bank 0 write request, qualified by ba_rd[0]
- ba0_addr..ba3_addr  in  SDRAMW each  per-bank word address
- ba0_din  in  16  bank 0 write data
- ba0_din_m  in  2  bank 0 write mask, active-high masks byte
- ba_ack  out  4  one-cycle acceptance pulse, one-hot
- ba_dst  out  4  data-start strobe for the owning bank
- ba_rdy  out  4  data-ready / write-done strobe for the owning bank
- rfsh_en  in  1  refresh window open (LVBL low)
- sdram_req  out  1  command request to the engine
- sdram_we  out  1  write command
- sdram_ba  out  2  bank select
- sdram_addr  out  SDRAMW  command address
- sdram_din  out  16  write data
- sdram_mask  out  2  write mask
- sdram_rfsh  out  1  refresh command request
- sdram_gnt  in  1  engine accepted the current req/rfsh
- sdram_dst  in  1  engine data-start
- sdram_rdy  in  1  engine transaction complete

## Operation
- States: IDLE, ISSUE, BUSY, RFSH.
- IDLE: if a refresh is pending and rfsh_en=1, or pending count = RFSH_MAXPEND, go to RFSH. Otherwise, if any ba_rd bit is set, select a winner. Latch its bank number, address, write flag (bank 0 only: ba_wr), data and mask, then go to ISSUE. With no request and no refresh due, stay in IDLE.
- Refresh beats clients only under the rule above. An outstanding client transaction is never aborted.
- ISSUE: sdram_req=1 with the latched command. When sdram_gnt=1: pulse ba_ack[owner], drop sdram_req, go to BUSY.
- BUSY: ba_dst[owner]=sdram_dst and ba_rdy[owner]=sdram_rdy, combinational, zero cycles. On sdram_rdy go to IDLE.
- RFSH: sdram_rfsh=1 until sdram_gnt, then decrement the pending count and wait for sdram_rdy, then go to IDLE.
- Refresh timer: counts 0..RFSH_PERIOD-1 and wraps. On wrap the pending count increments, saturating at RFSH_MAXPEND.
- A client that drops ba_rd after being latched still has its transaction completed and its ack pulsed.
- ba_dst/ba_rdy are 0 outside BUSY; strobes seen in other states are ignored.
- Outputs are only valid for the owner; ba_ack, ba_dst and ba_rdy are always one-hot or zero.

## Timing
- Reset values: all outputs 0; state IDLE; round-robin pointer at bank 0; timer and pending count 0.
- Reset asserted mid-transaction returns everything to reset values immediately. The engine must be reset together with this block.
- Arbitration latency: ba_rd seen in IDLE at cycle N gives sdram_req=1 at N+1. ba_ack appears in the same cycle sdram_gnt is sampled high; minimum ack is N+1.
- Back-to-back: after sdram_rdy at cycle M, the next arbitration happens at M+1 and the next sdram_req at M+2.
- If the timer wraps in the same cycle that RFSH's grant decrements the count, the net count is unchanged.

## Configuration
- JTCPS1_BANK_RR_EN defined: round-robin arbitration. Search starts at (last owner+1) mod 4, so every bank waits at most three transactions.
- JTCPS1_BANK_RR_EN undefined: fixed priority 0 > 1 > 3 > 2 (CPU first, then PCM, then graphics); the pointer register is removed.

## Structure
- Package jtcps1_arb_pkg holds:
  - the state enum (IDLE, ISSUE, BUSY, RFSH);
  - NBANKS=4;
  - timer and pending-count width functions of RFSH_PERIOD/RFSH_MAXPEND;
  - the fixed-priority order constant.
- One sub-module, jtcps1_arb_sel: combinational winner select. Inputs: request vector and pointer. Outputs: one-hot grant plus encoded bank.

## Test plan
- Single read: ba_rd=4'b0100, ba2_addr=23'h12345; engine gnt after 2 cycles and rdy after 6 cycles. Expect sdram_ba=2, sdram_addr=23'h12345, one ba_ack[2] pulse, ba_dst[2] and ba_rdy[2] mirroring the engine, nothing on other banks.
- Bank 0 write: ba_rd[0]=1, ba_wr=1, din=16'hBEEF, mask=2'b01. Expect sdram_we=1, sdram_din=16'hBEEF, sdram_mask=2'b01.
- Contention: all four banks request continuously for 8 transactions. With RR_EN expect grant order 0,1,2,3,0,1,2,3. Without it expect bank 0 every time.
- Refresh window: RFSH_PERIOD=20, rfsh_en=1, clients idle. Expect sdram_rfsh once per 20 cycles, and none while rfsh_en=0 until pending reaches 3; then the refresh is forced even with clients requesting.
- Dropped request: ba_rd[1] deasserted one cycle after latching. Expect the transaction still issued, ba_ack[1] still pulsed, and return to IDLE after sdram_rdy.
- Reset mid-BUSY: rst pulsed during a bank 3 read. Expect all outputs 0 within the reset cycle and a fresh grant to bank 0 when requests resume.
